req_arbiter: RTL and testbench
==============================

# req_arbiter

Eight-way request arbiter that shares one downstream resource among requesters, using the same bit-per-requester request vector the priority encoder consumes. It selects a winner in round-robin or fixed-priority mode, holds the grant while the owner keeps requesting, and forces re-arbitration after a bounded hold time. It sits between the requesters and the shared datapath. Its registered grant index drives the resource mux select.

## Interface
- `N`, 8 — number of requesters; must be a power of two, at least 2.
- `IDW`, 3 — index width, equal to log2(`N`).
- `MAX_HOLD`, 16 — maximum consecutive cycles one owner may hold the grant; must be at least 2.
- `clk  in  1` — single clock; everything is updated on the rising edge.
- `rst_n  in  1` — asynchronous, active-low reset.
- `req  in  N` — request vector; bit i is requester i. Level-sensitive.
- `mode  in  1` — 0 selects round-robin; 1 selects fixed priority, where the highest index wins.
- `gnt  out  N` — registered one-hot grant; all zeros when nothing is granted.
- `gnt_id  out  IDW` — index of the current owner; valid only while `gnt_valid` is 1.
- `gnt_valid  out  1` — 1 when exactly one `gnt` bit is set.
- `timeout  out  1` — one-cycle pulse on the edge where a hold-limit pre-emption takes effect.

## Operation
- States:
  - IDLE: no owner.
  - OWNED: one requester holds the grant.
- Arbitration event: the edge on which a new winner is computed. It occurs in these cases:
  - IDLE with `req` non-zero.
  - OWNED with `req[gnt_id]` equal to 0 (release).
  - OWNED with the hold limit reached (timeout).
- Winner search is performed over a candidate vector:
  - Release and IDLE use `req` as the candidate vector.
  - Timeout uses `req` with the owner bit masked.
  - If the masked vector is zero, the owner is re-granted and the hold counter restarts.
  - In that re-grant case `timeout` still pulses.
- Round-robin winner: the first set candidate bit found scanning upward from `last`+1, wrapping modulo N.
  - `last` is the index of the most recent grant.
  - `last` updates on every grant, including re-grants.
- Fixed-priority winner: the highest-index set candidate bit. `last` is still updated in this mode.
- `mode` is sampled only at arbitration events. A mode change never pre-empts the current owner.
- Transitions:
  - IDLE → OWNED on an arbitration event that finds a winner.
  - OWNED → OWNED on release with another request pending. The new grant takes effect on the same edge, with no idle bubble.
  - OWNED → IDLE on release with `req` all zero.
  - OWNED → OWNED on timeout.
- Hold counter:
  - Width is ceil(log2(`MAX_HOLD`)).
  - It is cleared to 0 on every grant.
  - It increments each cycle while OWNED and the owner is still requesting.
  - Timeout fires on the edge where the counter equals `MAX_HOLD`-1 and `req[gnt_id]` is 1.
  - Therefore an uncontested hold lasts at most `MAX_HOLD` cycles.
- Release has priority over timeout on the same edge: it is treated as a release, and `timeout` stays 0.
- Non-owner request bits have no effect until the next arbitration event.

## Timing
- Reset values, applied asynchronously while `rst_n` is 0:
  - `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0.
  - State is IDLE, hold counter is 0.
  - `last`=N-1, so the first round-robin search starts at index 0.
- Reset release is synchronous-safe: the first arbitration happens on the first rising edge with `rst_n` high.
- Grant latency: `req` sampled at edge k produces `gnt` after edge k. This is one registered cycle; there is no combinational path from `req` to `gnt`.
- Release latency: the owner drops `req` before edge k; `gnt` changes after edge k.
- Reset asserted mid-grant clears `gnt` immediately, without waiting for a clock edge.
- Invariants:
  - `gnt` is always zero or one-hot.
  - `gnt_valid` equals OR-reduce(`gnt`).
  - `gnt_id` equals the encoded `gnt` whenever `gnt_valid` is 1.
  - `timeout` is never high for two consecutive cycles.

## Test plan
- Reset, then a single request:
  - After reset, `gnt`=0 and `gnt_valid`=0.
  - Drive `req`=8'b0000_0100, `mode`=0.
  - One edge later: `gnt`=8'b0000_0100, `gnt_id`=2, `gnt_valid`=1.
  - Drop `req` to 0: after the next edge, `gnt`=0 and the block is IDLE.
- Round-robin rotation:
  - From reset, hold `req`=8'hFF with `mode`=0.
  - Each owner releases for one cycle after being granted.
  - Required grant order: 0,1,2,…,7,0. No index is repeated before all 8 have been served.
- Fixed priority:
  - Drive `mode`=1, `req`=8'b0101_0010 from IDLE: grant goes to 6.
  - Owner 6 releases: grant goes to 4, then to 1, each with no idle cycle in between.
- Hold-limit pre-emption:
  - `MAX_HOLD`=16, `mode`=0. Requester 3 is granted and holds.
  - Requester 5 asserts at cycle 2 of the hold.
  - On the 16th owned cycle: `timeout` pulses, and `gnt` switches to 8'b0010_0000.
  - Repeat with requester 3 alone: `timeout` pulses, `gnt` stays 8'b0000_1000, and the counter restarts.
- Release on the timeout edge:
  - The owner drops `req` on the same edge the counter reaches 15.
  - Required: `timeout`=0, and the handover follows the normal release rules.
- Asynchronous reset mid-grant:
  - Assert `rst_n`=0 between clock edges while `gnt`=8'b1000_0000.
  - `gnt` must be 0 immediately.
  - After release with `req`=8'hFF and `mode`=0, the first grant goes to index 0.

Source files
------------

// File: rtl/req_arbiter.sv
// -----------------------------------------------------------------------------
// req_arbiter
//
// Eight-way (parameterisable) request arbiter for a shared downstream resource.
// Selects a winner in round-robin or fixed-priority mode. The grant is held
// while the owner keeps requesting. A hold counter forces re-arbitration once
// one owner has held the grant for MAX_HOLD consecutive cycles. All outputs are
// registered, so there is no combinational path from req to gnt.
//
// Parameters
//   N         number of requesters (power of two, >= 2)
//   IDW       index width, log2(N)
//   MAX_HOLD  maximum consecutive owned cycles (>= 2)
//
// Ports
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   req        in   N     level-sensitive request vector, bit i = requester i
//   mode       in   1     0 = round-robin, 1 = fixed priority (highest index)
//   gnt        out  N     registered one-hot grant, zero when nothing granted
//   gnt_id     out  IDW   index of current owner, valid while gnt_valid = 1
//   gnt_valid  out  1     OR-reduction of gnt
//   timeout    out  1     one-cycle pulse when a hold-limit pre-emption lands
// -----------------------------------------------------------------------------
module req_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           mode,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    localparam int CW = $clog2(MAX_HOLD);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] last, last_nx;
    logic [CW-1:0]  hold_cnt, hold_cnt_nx;
    logic [N-1:0]   gnt_nx;
    logic [IDW-1:0] gnt_id_nx;
    logic           gnt_valid_nx;
    logic           timeout_nx;

    logic           owner_req;
    logic           release_ev;
    logic           hold_hit;
    logic [N-1:0]   cand;
    logic           rr_found, fp_found, win_found;
    logic [IDW-1:0] rr_idx, fp_idx, win_idx;

    // Arbitration event decode and winner search.
    always_comb begin : search
        logic [IDW-1:0] idx;
        owner_req  = req[gnt_id];
        release_ev = (state == OWNED) && !owner_req;
        // Release wins over timeout: hold_hit requires the owner still requesting.
        hold_hit   = (state == OWNED) && owner_req && (hold_cnt == CW'(MAX_HOLD - 1));

        // On a timeout the owner is masked so another requester gets a turn.
        cand = req;
        if (hold_hit) cand[gnt_id] = 1'b0;

        // Round-robin: scan upward from last+1; the index arithmetic wraps
        // naturally because N is a power of two. i = N lands back on last.
        rr_found = 1'b0;
        rr_idx   = '0;
        idx      = '0;
        for (int i = 1; i <= N; i++) begin
            idx = last + IDW'(i);
            if (!rr_found && cand[idx]) begin
                rr_found = 1'b1;
                rr_idx   = idx;
            end
        end

        // Fixed priority: ascending scan, so the last hit is the highest index.
        fp_found = 1'b0;
        fp_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                fp_found = 1'b1;
                fp_idx   = IDW'(i);
            end
        end

        win_found = mode ? fp_found : rr_found;
        win_idx   = mode ? fp_idx   : rr_idx;
    end

    // Next-state and next-output logic.
    always_comb begin : next_state
        // NOTE: every variable gets a default here, so no path can leave one
        // unassigned and infer a latch.
        state_nx     = state;
        last_nx      = last;
        hold_cnt_nx  = hold_cnt;
        gnt_nx       = gnt;
        gnt_id_nx    = gnt_id;
        gnt_valid_nx = gnt_valid;
        timeout_nx   = 1'b0;

        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_nx         = OWNED;
                    gnt_nx           = '0;
                    gnt_nx[win_idx]  = 1'b1;
                    gnt_id_nx        = win_idx;
                    gnt_valid_nx     = 1'b1;
                    last_nx          = win_idx;
                    hold_cnt_nx      = '0;
                end
            end

            OWNED: begin
                if (release_ev || hold_hit) begin
                    timeout_nx = hold_hit;
                    if (win_found) begin
                        // Handover on the same edge: no idle bubble.
                        gnt_nx          = '0;
                        gnt_nx[win_idx] = 1'b1;
                        gnt_id_nx       = win_idx;
                        gnt_valid_nx    = 1'b1;
                        last_nx         = win_idx;
                        hold_cnt_nx     = '0;
                    end else if (hold_hit) begin
                        // Nobody else waiting: re-grant the owner, restart the count.
                        last_nx     = gnt_id;
                        hold_cnt_nx = '0;
                    end else begin
                        state_nx     = IDLE;
                        gnt_nx       = '0;
                        gnt_valid_nx = 1'b0;
                        hold_cnt_nx  = '0;
                    end
                end else begin
                    hold_cnt_nx = hold_cnt + CW'(1);
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= IDW'(N - 1);
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            hold_cnt  <= hold_cnt_nx;
            gnt       <= gnt_nx;
            gnt_id    <= gnt_id_nx;
            gnt_valid <= gnt_valid_nx;
            timeout   <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_req_arbiter
//
// Self-checking bench for req_arbiter (N=8, MAX_HOLD=16). A table of
// {reset, req, mode, expected gnt, expected timeout} records covers the basic
// grant, round-robin rotation and fixed-priority cases; hand-written sequences
// cover hold-limit pre-emption, re-grant, release on the timeout edge and an
// asynchronous reset during a grant. Expected values are queued when stimulus
// is driven and popped when the DUT output is sampled after the edge.
// -----------------------------------------------------------------------------
module tb_req_arbiter;

    localparam int N        = 8;
    localparam int IDW      = 3;
    localparam int MAX_HOLD = 16;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic           mode;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           timeout;

    req_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mode      (mode),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [7:0] req;
        bit         mode;
        logic [7:0] gnt;
        bit         to;
    } vec_t;

    typedef struct {
        logic [7:0] gnt;
        bit         to;
        string      name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec;
    int   n_bad;
    bit   prev_to;

    function automatic vec_t mk(bit r, logic [7:0] q, bit m, logic [7:0] g, bit t);
        vec_t v;
        v.rst = r; v.req = q; v.mode = m; v.gnt = g; v.to = t;
        return v;
    endfunction

    function automatic logic [2:0] enc(logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {to,valid,id,gnt}=%b_%b_%b_%b required %b_%b_%b_%b",
                     name, act[12], act[11], act[10:8], act[7:0],
                     exp[12], exp[11], exp[10:8], exp[7:0]);
        end
    endtask

    // Drive one cycle of stimulus, then compare outputs after the edge.
    task automatic step(input logic [7:0] r, input bit m, input logic [7:0] g,
                        input bit to, input string name);
        exp_t e;
        logic [2:0] act_id;
        @(negedge clk);
        req  = r;
        mode = m;
        e.gnt = g; e.to = to; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 13'h1, 13'h0);
        end else begin
            e = sb.pop_front();
            act_id = (e.gnt != 0) ? gnt_id : 3'b0;
            check(e.name, {timeout, gnt_valid, act_id, gnt},
                          {e.to, |e.gnt, enc(e.gnt), e.gnt});
            if (prev_to && timeout) check({e.name, "_to_twice"}, 13'h1, 13'h0);
        end
        prev_to = timeout;
    endtask

    // Assert reset a few ns into the current cycle (between edges), check
    // that outputs clear without a clock edge, then release at a falling edge.
    task automatic do_reset(input string name);
        #3;
        rst_n = 1'b0;
        req   = '0;
        mode  = 1'b0;
        #1;
        check(name, {timeout, gnt_valid, gnt_id, gnt}, 13'h0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        prev_to = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        prev_to = 1'b0;
        rst_n   = 1'b1;
        req     = '0;
        mode    = 1'b0;

        // Single request, then release to idle.
        tbl.push_back(mk(1, 8'h04, 0, 8'h04, 0));
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0));
        // Round-robin rotation from reset: each owner drops for one cycle.
        tbl.push_back(mk(1, 8'hFF, 0, 8'h01, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 8'hFF & ~(8'h01 << i), 0, 8'h01 << ((i + 1) % 8), 0));
        // Fixed priority: 6, then 4, then 1 with no idle cycle.
        tbl.push_back(mk(1, 8'h52, 1, 8'h40, 0));
        tbl.push_back(mk(0, 8'h12, 1, 8'h10, 0));
        tbl.push_back(mk(0, 8'h02, 1, 8'h02, 0));
        tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0));
        // last = 1: round-robin from idle picks 2; a mode flip does not pre-empt.
        tbl.push_back(mk(0, 8'h06, 0, 8'h04, 0));
        tbl.push_back(mk(0, 8'h06, 1, 8'h04, 0));
        tbl.push_back(mk(0, 8'h02, 1, 8'h02, 0));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset($sformatf("reset_vec%0d", i));
            step(tbl[i].req, tbl[i].mode, tbl[i].gnt, tbl[i].to, $sformatf("vec%0d", i));
        end

        // Hold-limit pre-emption: 3 holds, 5 joins at hold cycle 2.
        do_reset("reset_hold");
        step(8'h08, 0, 8'h08, 0, "hold_grant3");
        for (int c = 1; c < MAX_HOLD; c++)
            step((c >= 2) ? 8'h28 : 8'h08, 0, 8'h08, 0, $sformatf("hold3_c%0d", c));
        step(8'h28, 0, 8'h20, 1, "preempt_to5");
        step(8'h28, 0, 8'h20, 0, "after_preempt");

        // Requester 3 alone: re-granted on timeout, counter restarts.
        step(8'h08, 0, 8'h08, 0, "rel5_grant3");
        for (int c = 1; c < MAX_HOLD; c++)
            step(8'h08, 0, 8'h08, 0, $sformatf("solo_a_c%0d", c));
        step(8'h08, 0, 8'h08, 1, "regrant_to1");
        for (int c = 1; c < MAX_HOLD; c++)
            step(8'h08, 0, 8'h08, 0, $sformatf("solo_b_c%0d", c));
        step(8'h08, 0, 8'h08, 1, "regrant_to2");
        step(8'h00, 0, 8'h00, 0, "solo_release");

        // Owner releases on the edge where the counter has reached 15.
        step(8'h08, 0, 8'h08, 0, "edge_grant3");
        for (int c = 1; c < MAX_HOLD; c++)
            step(8'h28, 0, 8'h08, 0, $sformatf("edge_c%0d", c));
        step(8'h20, 0, 8'h20, 0, "release_on_to_edge");

        // Asynchronous reset while 7 owns the grant.
        step(8'h80, 0, 8'h80, 0, "grant7");
        do_reset("async_reset_mid_grant");
        step(8'hFF, 0, 8'h01, 0, "first_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
